// File: rtl/uart_pkg.sv
// Shared constants, register offsets and FSM state types for the memory-mapped UART.
package uart_pkg;

  // Word offsets, decoded from addr[3:2]
  localparam logic [1:0] UART_TXDATA  = 2'd0;
  localparam logic [1:0] UART_RXDATA  = 2'd1;
  localparam logic [1:0] UART_STATUS  = 2'd2;
  localparam logic [1:0] UART_BAUDDIV = 2'd3;

  localparam int unsigned ST_TX_FULL   = 0;
  localparam int unsigned ST_TX_EMPTY  = 1;
  localparam int unsigned ST_RX_VALID  = 2;
  localparam int unsigned ST_RX_FULL   = 3;
  localparam int unsigned ST_OVERRUN   = 4;
  localparam int unsigned ST_TX_BUSY   = 5;
  localparam int unsigned ST_FRAME_ERR = 6;

  localparam logic [15:0] BAUD_MIN = 16'd4;

  typedef enum logic [1:0] {
    TxIdle,
    TxStart,
    TxData,
    TxStop
  } tx_state_e;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop,
    RxWaitHigh
  } rx_state_e;

  function automatic logic [15:0] clamp_baud(input logic [15:0] v);
    return (v < BAUD_MIN) ? BAUD_MIN : v;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO with combinational head read; push-when-full is dropped unless a pop
// happens in the same cycle.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == DEPTH_CNT);
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_rdata   = r_mem[r_rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TX/RX FIFOs, programmable baud divider, sticky error flags and
// combinational register reads for a zero-wait-state load path.
module uart_mmio
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_n,
  input  logic        we,
  input  logic        re,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wbe,
  output logic [31:0] rdata,
  output logic        uart_txd,
  input  logic        uart_rxd
);

  localparam logic [15:0] BAUD_RESET = 16'(CLOCK_FREQ / BAUD_RATE);

  logic [1:0]  w_reg;
  logic        w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
  logic        w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
  logic        w_rx_ferr, w_overrun_set, w_stat_wr, w_baud_wr, w_rx_in;
  logic [7:0]  w_tx_head, w_rx_head;
  logic [15:0] w_baud_new;
  logic [31:0] w_status;
  logic        w_unused;

  logic [15:0] r_baud;
  logic        r_overrun, r_frame_err;

  tx_state_e   r_tx_state;
  logic        r_txd, r_tx_pend;
  logic [7:0]  r_tx_shift;
  logic [15:0] r_tx_cnt, r_tx_div;
  logic [2:0]  r_tx_bit;

  rx_state_e   r_rx_state;
  logic [1:0]  r_sync;
  logic        r_rx_prev;
  logic [7:0]  r_rx_shift;
  logic [15:0] r_rx_cnt, r_rx_div;
  logic [2:0]  r_rx_bit;

  assign w_unused = ^{addr[1:0], wdata[31:16], wbe[3:2]};

  assign w_reg      = addr[3:2];
  assign w_tx_push  = ~cs_n & we & (w_reg == UART_TXDATA) & wbe[0];
  assign w_rx_pop   = ~cs_n & re & ~we & (w_reg == UART_RXDATA);
  assign w_stat_wr  = ~cs_n & we & (w_reg == UART_STATUS) & wbe[0];
  assign w_baud_wr  = ~cs_n & we & (w_reg == UART_BAUDDIV) & (|wbe[1:0]);
  assign w_baud_new = {wbe[1] ? wdata[15:8] : r_baud[15:8], wbe[0] ? wdata[7:0] : r_baud[7:0]};

  assign w_tx_pop = ~w_tx_empty & (((r_tx_state == TxIdle) & ~r_tx_pend) |
                                   ((r_tx_state == TxStop) & (r_tx_cnt == '0)));

  assign w_rx_in       = r_sync[1];
  assign w_rx_push     = (r_rx_state == RxStop) & (r_rx_cnt == '0) & w_rx_in;
  assign w_rx_ferr     = (r_rx_state == RxStop) & (r_rx_cnt == '0) & ~w_rx_in;
  assign w_overrun_set = w_rx_push & w_rx_full & ~w_rx_pop;

  assign uart_txd = r_txd;

  uart_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_tx_push),
    .i_pop   (w_tx_pop),
    .i_wdata (wdata[7:0]),
    .o_rdata (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  uart_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_rx_push),
    .i_pop   (w_rx_pop),
    .i_wdata (r_rx_shift),
    .o_rdata (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  // Control registers and sticky flags; a set in the same cycle as a W1C wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_baud      <= BAUD_RESET;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_baud_wr) r_baud <= clamp_baud(w_baud_new);
      r_overrun   <= w_overrun_set | (r_overrun & ~(w_stat_wr & wdata[ST_OVERRUN]));
      r_frame_err <= w_rx_ferr | (r_frame_err & ~(w_stat_wr & wdata[ST_FRAME_ERR]));
    end
  end

  // Transmitter: the pop cycle out of idle is a one-cycle load slot before the start bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_state <= TxIdle;
      r_txd      <= 1'b1;
      r_tx_pend  <= 1'b0;
      r_tx_shift <= '0;
      r_tx_cnt   <= '0;
      r_tx_div   <= BAUD_RESET;
      r_tx_bit   <= '0;
    end else begin
      unique case (r_tx_state)
        TxIdle: begin
          r_txd <= 1'b1;
          if (r_tx_pend) begin
            r_tx_state <= TxStart;
            r_txd      <= 1'b0;
            r_tx_cnt   <= r_tx_div - 16'd1;
            r_tx_pend  <= 1'b0;
          end else if (!w_tx_empty) begin
            r_tx_shift <= w_tx_head;
            r_tx_div   <= r_baud;
            r_tx_pend  <= 1'b1;
          end
        end
        TxStart: begin
          if (r_tx_cnt == '0) begin
            r_tx_state <= TxData;
            r_txd      <= r_tx_shift[0];
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            r_tx_bit   <= '0;
            r_tx_cnt   <= r_tx_div - 16'd1;
          end else begin
            r_tx_cnt <= r_tx_cnt - 16'd1;
          end
        end
        TxData: begin
          if (r_tx_cnt == '0) begin
            r_tx_cnt <= r_tx_div - 16'd1;
            if (r_tx_bit == 3'd7) begin
              r_tx_state <= TxStop;
              r_txd      <= 1'b1;
            end else begin
              r_tx_bit   <= r_tx_bit + 3'd1;
              r_txd      <= r_tx_shift[0];
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            end
          end else begin
            r_tx_cnt <= r_tx_cnt - 16'd1;
          end
        end
        TxStop: begin
          if (r_tx_cnt == '0) begin
            if (!w_tx_empty) begin
              r_tx_state <= TxStart;
              r_txd      <= 1'b0;
              r_tx_shift <= w_tx_head;
              r_tx_div   <= r_baud;
              r_tx_cnt   <= r_baud - 16'd1;
            end else begin
              r_tx_state <= TxIdle;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt - 16'd1;
          end
        end
        default: r_tx_state <= TxIdle;
      endcase
    end
  end

  // Receiver: start bit checked at mid-period, then one sample per full period
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync     <= 2'b11;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RxIdle;
      r_rx_shift <= '0;
      r_rx_cnt   <= '0;
      r_rx_div   <= BAUD_RESET;
      r_rx_bit   <= '0;
    end else begin
      r_sync    <= {r_sync[0], uart_rxd};
      r_rx_prev <= w_rx_in;
      unique case (r_rx_state)
        RxIdle: begin
          if (r_rx_prev && !w_rx_in) begin
            r_rx_state <= RxStart;
            r_rx_div   <= r_baud;
            r_rx_cnt   <= (r_baud >> 1) - 16'd1;
          end
        end
        RxStart: begin
          if (r_rx_cnt == '0) begin
            if (w_rx_in) begin
              r_rx_state <= RxIdle;
            end else begin
              r_rx_state <= RxData;
              r_rx_bit   <= '0;
              r_rx_cnt   <= r_rx_div - 16'd1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt - 16'd1;
          end
        end
        RxData: begin
          if (r_rx_cnt == '0) begin
            r_rx_shift <= {w_rx_in, r_rx_shift[7:1]};
            r_rx_cnt   <= r_rx_div - 16'd1;
            if (r_rx_bit == 3'd7) r_rx_state <= RxStop;
            else                  r_rx_bit   <= r_rx_bit + 3'd1;
          end else begin
            r_rx_cnt <= r_rx_cnt - 16'd1;
          end
        end
        RxStop: begin
          if (r_rx_cnt == '0) begin
            r_rx_state <= w_rx_in ? RxIdle : RxWaitHigh;
          end else begin
            r_rx_cnt <= r_rx_cnt - 16'd1;
          end
        end
        RxWaitHigh: begin
          if (w_rx_in) r_rx_state <= RxIdle;
        end
        default: r_rx_state <= RxIdle;
      endcase
    end
  end

  always_comb begin
    w_status               = '0;
    w_status[ST_TX_FULL]   = w_tx_full;
    w_status[ST_TX_EMPTY]  = w_tx_empty;
    w_status[ST_RX_VALID]  = ~w_rx_empty;
    w_status[ST_RX_FULL]   = w_rx_full;
    w_status[ST_OVERRUN]   = r_overrun;
    w_status[ST_TX_BUSY]   = (r_tx_state != TxIdle);
    w_status[ST_FRAME_ERR] = r_frame_err;
  end

  always_comb begin
    rdata = '0;
    if (!cs_n) begin
      unique case (w_reg)
        UART_TXDATA:  rdata = '0;
        UART_RXDATA:  rdata = {w_rx_empty, 23'b0, w_rx_head & {8{~w_rx_empty}}};
        UART_STATUS:  rdata = w_status;
        UART_BAUDDIV: rdata = {16'b0, r_baud};
        default:      rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio: register access, TX timing and queueing, RX path,
// overrun, framing error, glitch rejection and asynchronous reset.
module tb_uart_mmio;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs_n = 1'b1;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wbe = '0;
  logic [31:0] rdata;
  logic        uart_txd;
  logic        uart_rxd = 1'b1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int tb_baud = 8;

  // TX line decoder state
  bit         mon_en = 1'b0;
  logic [7:0] mon_q[$];
  int         start_q[$];
  int         mon_stop_bad = 0;
  int         mon_s;
  logic [7:0] mon_b;
  logic       mon_stop;

  uart_mmio dut (
    .clk      (clk),
    .reset    (reset),
    .cs_n     (cs_n),
    .we       (we),
    .re       (re),
    .addr     (addr),
    .wdata    (wdata),
    .wbe      (wbe),
    .rdata    (rdata),
    .uart_txd (uart_txd),
    .uart_rxd (uart_rxd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : tx_mon
    forever begin
      @(posedge clk); #1;
      if (mon_en && uart_txd === 1'b0) begin
        mon_s = cyc;
        for (int i = 0; i < 8; i++) begin
          while (cyc < mon_s + tb_baud * (i + 1) + tb_baud / 2) begin @(posedge clk); #1; end
          mon_b[i] = uart_txd;
        end
        while (cyc < mon_s + tb_baud * 9 + tb_baud / 2) begin @(posedge clk); #1; end
        mon_stop = uart_txd;
        while (cyc < mon_s + tb_baud * 10 - 1) begin @(posedge clk); #1; end
        if (mon_en) begin
          mon_q.push_back(mon_b);
          start_q.push_back(mon_s);
          if (mon_stop !== 1'b1) mon_stop_bad++;
        end
      end
    end
  end

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    cs_n = 1'b0; we = 1'b1; re = 1'b0; addr = a; wdata = d; wbe = be;
    @(posedge clk); #1;
    cs_n = 1'b1; we = 1'b0; wbe = '0;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic pop, output logic [31:0] d);
    @(negedge clk);
    cs_n = 1'b0; we = 1'b0; re = pop; addr = a;
    #1 d = rdata;
    @(posedge clk); #1;
    cs_n = 1'b1; re = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      uart_rxd = f[i];
      repeat (tb_baud - 1) @(negedge clk);
    end
    @(negedge clk);
    uart_rxd = 1'b1;
    repeat (2 * tb_baud) @(negedge clk);
  endtask

  task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (uart_txd !== 1'b1) begin bad++; $display("FAIL reset_txd: got=%b expected=1", uart_txd); end
    @(negedge clk); reset = 1'b0;
    bus_read(4'h8, 1'b0, d); check_word("reset_status", d, 32'h2);
    bus_read(4'hC, 1'b0, d); check_word("reset_baud", d, 32'd434);
    bus_read(4'h4, 1'b0, d); check_word("reset_rxdata", d, 32'h8000_0000);
    bus_read(4'h0, 1'b0, d); check_word("txdata_read", d, 32'h0);
    #1 check_word("deselected_rdata", rdata, 32'h0);
  endtask

  task automatic test_regs();
    logic [31:0] d;
    logic [15:0] v;
    logic [15:0] exp;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) v = 16'(i * 3);
      else       v = 16'($urandom_range(0, 65535));
      exp = (v < 16'd4) ? 16'd4 : v;
      bus_write(4'hC, {16'($urandom), v}, 4'hF);
      bus_read(4'hC, 1'b0, d);
      check_word("baud_write", d, {16'h0, exp});
    end
    bus_write(4'hC, 32'd8, 4'hF);
    tb_baud = 8;
    // A TXDATA write without byte 0 enabled must not queue anything
    bus_write(4'h0, 32'h55, 4'hE);
    bus_read(4'h8, 1'b0, d);
    check_word("tx_no_be_status", d, 32'h2);
  endtask

  task automatic test_tx_frame();
    logic [7:0] b;
    int w;
    int t;
    logic exp;
    b = 8'h41;
    bus_write(4'h0, {24'h0, b}, 4'h1);
    w = cyc;
    cs_n = 1'b0; addr = 4'h8;
    for (int k = 0; k < 85; k++) begin
      @(posedge clk); #1;
      t = cyc - w;
      if (t < 2)                  exp = 1'b1;
      else if (t < 2 + tb_baud)   exp = 1'b0;
      else if (t < 2 + 9 * tb_baud) exp = b[(t - 2 - tb_baud) / tb_baud];
      else                        exp = 1'b1;
      total++;
      if (uart_txd !== exp) begin
        bad++;
        $display("FAIL tx_wave t=%0d: got=%b expected=%b", t, uart_txd, exp);
      end
      if (t == 1) begin
        total++;
        if (rdata[1] !== 1'b1) begin bad++; $display("FAIL tx_pop_1cyc: got=%b expected=1", rdata[1]); end
      end
      if (t == 2 || t == 81 || t == 82) begin
        total++;
        if (rdata[5] !== (t != 82)) begin
          bad++;
          $display("FAIL tx_busy t=%0d: got=%b expected=%b", t, rdata[5], t != 82);
        end
      end
    end
    cs_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [6];
    logic [7:0] fifo_m[$];
    logic [7:0] sent_m[$];
    logic [31:0] d;
    bit engine_busy;
    bit do_pop;
    bit accept;
    int w1;
    int n;
    engine_busy = 1'b0;
    mon_q.delete(); start_q.delete(); mon_stop_bad = 0;
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) begin
      do_pop = !engine_busy && fifo_m.size() > 0;
      accept = fifo_m.size() < 4 || do_pop;
      if (do_pop) begin sent_m.push_back(fifo_m.pop_front()); engine_busy = 1'b1; end
      if (accept) fifo_m.push_back(bytes[i]);
    end
    foreach (fifo_m[i]) sent_m.push_back(fifo_m[i]);
    for (int i = 0; i < 6; i++) begin
      bus_write(4'h0, {24'h0, bytes[i]}, 4'h1);
      if (i == 0) w1 = cyc;
    end
    bus_read(4'h8, 1'b0, d);
    check_word("b2b_status_full", d, {26'h0, 1'b1, 4'h0, fifo_m.size() == 4});
    n = 0;
    while (mon_q.size() < sent_m.size() && n < 2000) begin @(posedge clk); n++; end
    repeat (200) @(posedge clk);
    mon_en = 1'b0;
    check_word("b2b_frame_count", mon_q.size(), sent_m.size());
    for (int i = 0; i < mon_q.size() && i < sent_m.size(); i++)
      check_word("b2b_byte", {24'h0, mon_q[i]}, {24'h0, sent_m[i]});
    if (start_q.size() > 0) check_word("b2b_first_start", start_q[0] - w1, 32'd2);
    for (int i = 1; i < start_q.size(); i++)
      check_word("b2b_gap", start_q[i] - start_q[i-1], 10 * tb_baud);
    check_word("b2b_stop_bits", mon_stop_bad, 32'd0);
  endtask

  task automatic test_rx_basic();
    logic [31:0] d;
    send_rx(8'hA5, 1'b1);
    bus_read(4'h8, 1'b0, d); check_word("rx_status_valid", d, 32'h6);
    bus_read(4'h4, 1'b1, d); check_word("rx_pop_a5", d, 32'h0000_00A5);
    bus_read(4'h4, 1'b0, d); check_word("rx_reread_empty", d, 32'h8000_0000);
  endtask

  task automatic test_rx_overrun();
    logic [7:0] model_q[$];
    logic [7:0] b;
    logic [31:0] d;
    bit ovr;
    ovr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      if (model_q.size() < 4) model_q.push_back(b);
      else ovr = 1'b1;
      send_rx(b, 1'b1);
    end
    bus_read(4'h8, 1'b0, d);
    check_word("ovr_status", d, {27'h0, ovr, model_q.size() == 4, 1'b1, 2'b10});
    while (model_q.size() > 0) begin
      bus_read(4'h4, 1'b1, d);
      check_word("ovr_pop", d, {24'h0, model_q.pop_front()});
    end
    bus_read(4'h8, 1'b0, d); check_word("ovr_status_drained", d, 32'h12);
    bus_write(4'h8, 32'h10, 4'h1);
    bus_read(4'h8, 1'b0, d); check_word("ovr_w1c", d, 32'h2);
  endtask

  task automatic test_frame_err();
    logic [7:0] good;
    logic [31:0] d;
    good = 8'($urandom);
    send_rx(good, 1'b1);
    send_rx(8'($urandom), 1'b0);
    bus_read(4'h8, 1'b0, d); check_word("ferr_status", d, 32'h46);
    bus_read(4'h4, 1'b1, d); check_word("ferr_pop_good", d, {24'h0, good});
    bus_read(4'h4, 1'b0, d); check_word("ferr_empty", d, 32'h8000_0000);
    bus_write(4'h8, 32'h40, 4'h1);
    bus_read(4'h8, 1'b0, d); check_word("ferr_w1c", d, 32'h2);
    // Short low pulse must be rejected as a glitch
    @(negedge clk); uart_rxd = 1'b0;
    repeat (2) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (12 * tb_baud) @(negedge clk);
    bus_read(4'h8, 1'b0, d); check_word("glitch_status", d, 32'h2);
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    int w;
    bus_write(4'h0, 32'h00, 4'h1);
    w = cyc;
    while (cyc < w + 20) begin @(posedge clk); #1; end
    total++;
    if (uart_txd !== 1'b0) begin bad++; $display("FAIL midframe_low: got=%b expected=0", uart_txd); end
    #2 reset = 1'b1;
    #1;
    total++;
    if (uart_txd !== 1'b1) begin bad++; $display("FAIL async_reset_txd: got=%b expected=1", uart_txd); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus_read(4'h8, 1'b0, d); check_word("post_reset_status", d, 32'h2);
    bus_read(4'hC, 1'b0, d); check_word("post_reset_baud", d, 32'd434);
  endtask

  initial begin
    test_reset();
    test_regs();
    test_tx_frame();
    test_back_to_back();
    test_rx_basic();
    test_rx_overrun();
    test_frame_err();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
